// File: rtl/mmio_uart_if.sv
// CPU p-bus slice seen by the UART peripheral: address, data and single-cycle strobes.
// The CPU drives the master side and the peripheral answers on the slave side.
interface mmio_uart_if;
    logic [31:0] paddr;
    logic [31:0] pread;
    logic [31:0] pwrite;
    logic        pread_req;
    logic        pwrite_req;
    logic [2:0]  psize;

    modport master (output paddr, pwrite, pread_req, pwrite_req, psize, input pread);
    modport slave  (input paddr, pwrite, pread_req, pwrite_req, psize, output pread);
endinterface

// File: rtl/mmio_uart.sv
// Memory-mapped 8N1 UART: TX FIFO into a serializer, RX deserializer into an RX FIFO.
// Register reads are combinational; writes and read-pops commit at the rising edge.
module mmio_uart_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] din_i,
    output logic [7:0] head_o,
    output logic       empty_o,
    output logic       full_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [CW-1:0] count_q;
    logic          do_push_s;
    logic          do_pop_s;

    // Full/empty come from the pre-edge count, so a same-edge pop never rescues a push.
    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CW'(DEPTH));
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;
    assign head_o    = mem_q[rptr_q];

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push_s) begin
                mem_q[wptr_q] <= din_i;
                wptr_q        <= wptr_q + AW'(1);
            end
            if (do_pop_s) begin
                rptr_q <= rptr_q + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

module mmio_uart #(
    parameter logic [31:0] BASE         = 32'hC000_0000,
    parameter int          CLKS_PER_BIT = 4,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic         clock,
    input  logic         reset,
    mmio_uart_if.slave   bus,
    output logic         uart_tx,
    input  logic         uart_rx
);
    localparam int BCW = $clog2(CLKS_PER_BIT);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(CLKS_PER_BIT - 1);
    localparam logic [BCW-1:0] HALF_LAST = BCW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_e;

    logic            hit_s, wr_tx_s, rd_rx_s, wr_st_s;
    logic [1:0]      sel_s;
    logic [31:0]     status_s;
    logic            unused_bits_s;

    logic [7:0]      tx_head_s;
    logic            tx_empty_s, tx_full_s, tx_idle_s;
    tx_state_e       tx_state_q;
    logic [BCW-1:0]  tx_cnt_q;
    logic [2:0]      tx_idx_q;
    logic [7:0]      tx_shift_q;
    logic            tx_line_q;

    logic [1:0]      sync_q;
    logic            rx_s;
    rx_state_e       rx_state_q;
    logic [BCW-1:0]  rx_cnt_q;
    logic [2:0]      rx_idx_q;
    logic [7:0]      rx_shift_q;
    logic            rx_stop_ok_s, rx_stop_bad_s;
    logic [7:0]      rx_head_s;
    logic            rx_empty_s, rx_full_s;

    logic            tx_ovf_q, rx_ovf_q, frame_err_q;

    assign hit_s   = (bus.paddr[31:4] == BASE[31:4]);
    assign sel_s   = bus.paddr[3:2];
    assign wr_tx_s = hit_s && bus.pwrite_req && (sel_s == 2'd0);
    assign rd_rx_s = hit_s && bus.pread_req  && (sel_s == 2'd1);
    assign wr_st_s = hit_s && bus.pwrite_req && (sel_s == 2'd2);

    // Size strobe, byte lane bits and upper write data carry no meaning here.
    assign unused_bits_s = ^{bus.psize, bus.paddr[1:0], bus.pwrite[31:8]};

    assign tx_idle_s = tx_empty_s && (tx_state_q == TX_IDLE);
    assign status_s  = {26'd0, frame_err_q, tx_ovf_q, rx_ovf_q, ~rx_empty_s, tx_idle_s, tx_full_s};

    always_comb begin
        bus.pread = 32'd0;
        if (hit_s) begin
            case (sel_s)
                2'd1:    bus.pread = {rx_empty_s, 23'd0, (rx_empty_s ? 8'd0 : rx_head_s)};
                2'd2:    bus.pread = status_s;
                default: bus.pread = 32'd0;
            endcase
        end else begin
            bus.pread = 32'd0;
        end
    end

    mmio_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (wr_tx_s),
        .pop_i   (tx_state_q == TX_IDLE),
        .din_i   (bus.pwrite[7:0]),
        .head_o  (tx_head_s),
        .empty_o (tx_empty_s),
        .full_o  (tx_full_s)
    );

    mmio_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (rx_stop_ok_s),
        .pop_i   (rd_rx_s),
        .din_i   (rx_shift_q),
        .head_o  (rx_head_s),
        .empty_o (rx_empty_s),
        .full_o  (rx_full_s)
    );

    // Serializer: every state lasts CLKS_PER_BIT cycles; the line is driven from a flop.
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= 3'd0;
            tx_shift_q <= 8'd0;
            tx_line_q  <= 1'b1;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (!tx_empty_s) begin
                        tx_shift_q <= tx_head_s;
                        tx_line_q  <= 1'b0;
                        tx_cnt_q   <= BIT_LAST;
                        tx_state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt_q == '0) begin
                        tx_line_q  <= tx_shift_q[0];
                        tx_cnt_q   <= BIT_LAST;
                        tx_idx_q   <= 3'd0;
                        tx_state_q <= TX_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q - BCW'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_q == '0) begin
                        tx_cnt_q <= BIT_LAST;
                        if (tx_idx_q == 3'd7) begin
                            tx_line_q  <= 1'b1;
                            tx_state_q <= TX_STOP;
                        end else begin
                            tx_line_q  <= tx_shift_q[1];
                            tx_shift_q <= {1'b1, tx_shift_q[7:1]};
                            tx_idx_q   <= tx_idx_q + 3'd1;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q - BCW'(1);
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_q == '0) begin
                        tx_state_q <= TX_IDLE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q - BCW'(1);
                    end
                end
                default: begin
                    tx_state_q <= TX_IDLE;
                    tx_line_q  <= 1'b1;
                end
            endcase
        end
    end

    assign uart_tx = tx_line_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], uart_rx};
        end
    end

    assign rx_s          = sync_q[1];
    assign rx_stop_ok_s  = (rx_state_q == RX_STOP) && (rx_cnt_q == '0) && rx_s;
    assign rx_stop_bad_s = (rx_state_q == RX_STOP) && (rx_cnt_q == '0) && !rx_s;

    // Deserializer: start is re-checked half a bit in, later samples land mid-bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= 3'd0;
            rx_shift_q <= 8'd0;
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (!rx_s) begin
                        rx_cnt_q   <= HALF_LAST;
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == '0) begin
                        if (rx_s) begin
                            rx_state_q <= RX_IDLE;
                        end else begin
                            rx_cnt_q   <= BIT_LAST;
                            rx_idx_q   <= 3'd0;
                            rx_state_q <= RX_DATA;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q - BCW'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == '0) begin
                        rx_shift_q <= {rx_s, rx_shift_q[7:1]};
                        rx_cnt_q   <= BIT_LAST;
                        rx_idx_q   <= rx_idx_q + 3'd1;
                        if (rx_idx_q == 3'd7) begin
                            rx_state_q <= RX_STOP;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q - BCW'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == '0) begin
                        rx_state_q <= rx_s ? RX_IDLE : RX_WAIT_HIGH;
                    end else begin
                        rx_cnt_q <= rx_cnt_q - BCW'(1);
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rx_s) begin
                        rx_state_q <= RX_IDLE;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // Sticky flags: a set event on the same edge beats a write-one-to-clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_ovf_q    <= 1'b0;
            rx_ovf_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            tx_ovf_q    <= (wr_tx_s && tx_full_s) || (tx_ovf_q && !(wr_st_s && bus.pwrite[4]));
            rx_ovf_q    <= (rx_stop_ok_s && rx_full_s) || (rx_ovf_q && !(wr_st_s && bus.pwrite[3]));
            frame_err_q <= rx_stop_bad_s || (frame_err_q && !(wr_st_s && bus.pwrite[5]));
        end
    end
endmodule

// File: tb/tb_mmio_uart.sv
// Directed-plus-random bench for mmio_uart: a line-level frame decoder and byte queues
// model what the serial pins and registers should show.
module tb_mmio_uart;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam logic [31:0] A_TX  = 32'hC000_0000;
    localparam logic [31:0] A_RX  = 32'hC000_0004;
    localparam logic [31:0] A_ST  = 32'hC000_0008;
    localparam logic [31:0] A_RSV = 32'hC000_000C;

    logic clock   = 1'b0;
    logic reset   = 1'b1;
    logic uart_rx = 1'b1;
    logic uart_tx;

    int checks       = 0;
    int errors       = 0;
    int tx_stop_errs = 0;

    logic [7:0] tx_seen[$];
    logic [7:0] tx_exp[$];
    logic [7:0] rx_model[$];
    logic [7:0] mon_byte;
    logic       rx_ovf_model;

    mmio_uart_if bus_if();

    mmio_uart #(.BASE(32'hC000_0000), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus_if),
        .uart_tx (uart_tx),
        .uart_rx (uart_rx)
    );

    always #5 clock = ~clock;

    // Independent receiver on uart_tx: find the start bit, then sample each bit centre.
    initial begin
        forever begin
            @(negedge clock);
            if (uart_tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clock);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clock);
                    mon_byte[i] = uart_tx;
                end
                repeat (CPB) @(negedge clock);
                if (uart_tx !== 1'b1) tx_stop_errs++;
                tx_seen.push_back(mon_byte);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clock);
        bus_if.paddr      = addr;
        bus_if.pwrite     = data;
        bus_if.pwrite_req = 1'b1;
        @(posedge clock);
        #1;
        bus_if.pwrite_req = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clock);
        bus_if.paddr     = addr;
        bus_if.pread_req = 1'b1;
        #1;
        data = bus_if.pread;
        @(posedge clock);
        #1;
        bus_if.pread_req = 1'b0;
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            uart_rx = frame[i];
            repeat (CPB - 1) @(negedge clock);
        end
        @(negedge clock);
        uart_rx = 1'b1;
    endtask

    task automatic wait_tx(input int n, input int budget);
        int c;
        c = 0;
        while (tx_seen.size() < n && c < budget) begin
            @(negedge clock);
            c++;
        end
        chk("wait_tx_count", tx_seen.size(), n);
    endtask

    // Expected line level k cycles into a frame: start, eight data bits LSB first, stop.
    function automatic logic exp_line(input logic [7:0] b, input int k);
        int slot;
        slot = k / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        return 1'b1;
    endfunction

    task automatic rx_model_push(input logic [7:0] b);
        if (rx_model.size() < DEPTH) rx_model.push_back(b);
        else rx_ovf_model = 1'b1;
    endtask

    task automatic rx_read_check(input string tag);
        logic [31:0] rd;
        bus_read(A_RX, rd);
        if (rx_model.size() == 0) chk(tag, rd, 32'h8000_0000);
        else chk(tag, rd, {24'd0, rx_model.pop_front()});
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  b;
        int          n;
        int          lows;

        bus_if.paddr      = 32'd0;
        bus_if.pwrite     = 32'd0;
        bus_if.pread_req  = 1'b0;
        bus_if.pwrite_req = 1'b0;
        bus_if.psize      = 3'b100;
        rx_ovf_model      = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Reset state
        bus_read(A_ST, rd);  chk("reset_status", rd, 32'h0000_0002);
        bus_read(A_RX, rd);  chk("reset_rxdata", rd, 32'h8000_0000);
        chk("reset_tx_line", {31'd0, uart_tx}, 32'd1);
        bus_read(A_RSV, rd); chk("reserved_read", rd, 32'd0);
        bus_read(A_TX, rd);  chk("txdata_read", rd, 32'd0);

        // Single frame, exact waveform
        bus_write(A_TX, 32'h0000_0055);
        @(negedge clock);
        chk("tx_before_start", {31'd0, uart_tx}, 32'd1);
        for (int k = 0; k < 10 * CPB; k++) begin
            @(negedge clock);
            chk("tx_wave_55", {31'd0, uart_tx}, {31'd0, exp_line(8'h55, k)});
        end
        bus_read(A_ST, rd); chk("tx_idle_after_frame", rd, 32'h0000_0002);
        wait_tx(1, 20);
        if (tx_seen.size() > 0) chk("tx_decoded_55", {24'd0, tx_seen[0]}, 32'h55);
        tx_seen.delete();

        // Random bursts that fit in FIFO plus shift register
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 4);
            for (int j = 0; j < n; j++) begin
                b = 8'($urandom);
                bus_write(A_TX, {24'd0, b});
                tx_exp.push_back(b);
            end
            wait_tx(n, n * 11 * CPB + 20);
            for (int j = 0; j < n && j < tx_seen.size(); j++)
                chk("tx_burst_byte", {24'd0, tx_seen[j]}, {24'd0, tx_exp[j]});
            tx_seen.delete();
            tx_exp.delete();
            repeat (4) @(negedge clock);
        end

        // TX overflow: sixth back-to-back write is dropped
        for (int j = 0; j < 6; j++) begin
            b = 8'($urandom);
            bus_write(A_TX, {24'd0, b});
            if (j < 5) tx_exp.push_back(b);
        end
        bus_read(A_ST, rd);  chk("tx_ovf_status", rd, 32'h0000_0011);
        bus_write(A_ST, 32'h0000_0010);
        bus_read(A_ST, rd);  chk("tx_ovf_cleared", rd, 32'h0000_0001);
        wait_tx(5, 5 * 11 * CPB + 40);
        for (int j = 0; j < 5 && j < tx_seen.size(); j++)
            chk("tx_ovf_order", {24'd0, tx_seen[j]}, {24'd0, tx_exp[j]});
        chk("tx_stop_bits", tx_stop_errs, 32'd0);
        tx_seen.delete();
        tx_exp.delete();
        repeat (4) @(negedge clock);
        bus_read(A_ST, rd);  chk("tx_idle_after_burst", rd, 32'h0000_0002);

        // RX loopback
        rx_send(8'hA3, 1'b1);
        repeat (3) @(negedge clock);
        bus_read(A_ST, rd);  chk("rx_avail_set", rd, 32'h0000_0006);
        bus_read(32'hC000_0014, rd); chk("miss_read_rx", rd, 32'd0);
        bus_read(A_RX, rd);  chk("rx_data_a3", rd, 32'h0000_00A3);
        bus_read(A_ST, rd);  chk("rx_avail_clear", rd, 32'h0000_0002);

        // Glitch and framing error
        @(negedge clock); uart_rx = 1'b0;
        @(negedge clock); uart_rx = 1'b1;
        repeat (12) @(negedge clock);
        bus_read(A_ST, rd);  chk("rx_glitch", rd, 32'h0000_0002);
        rx_send(8'($urandom), 1'b0);
        repeat (3) @(negedge clock);
        bus_read(A_ST, rd);  chk("frame_err_set", rd, 32'h0000_0022);
        bus_write(A_ST, 32'h0000_0020);
        bus_read(A_ST, rd);  chk("frame_err_clear", rd, 32'h0000_0002);

        // RX overflow: five frames, no reads
        for (int j = 0; j < 5; j++) begin
            b = 8'($urandom);
            rx_send(b, 1'b1);
            rx_model_push(b);
            repeat (3) @(negedge clock);
        end
        bus_read(A_ST, rd);
        chk("rx_ovf_status", rd, {28'd0, rx_ovf_model, (rx_model.size() != 0), 2'b10});
        for (int j = 0; j < 5; j++) rx_read_check("rx_ovf_drain");
        bus_write(A_ST, 32'h0000_0008);
        rx_ovf_model = 1'b0;
        bus_read(A_ST, rd);  chk("rx_ovf_clear", rd, 32'h0000_0002);

        // Random RX traffic with random reads
        for (int r = 0; r < 8; r++) begin
            b = 8'($urandom);
            rx_send(b, 1'b1);
            rx_model_push(b);
            repeat (3) @(negedge clock);
            n = $urandom_range(0, 2);
            for (int j = 0; j < n; j++) rx_read_check("rx_rand_read");
        end
        bus_read(A_ST, rd);
        chk("rx_rand_status", rd, {28'd0, rx_ovf_model, (rx_model.size() != 0), 2'b10});
        while (rx_model.size() != 0) rx_read_check("rx_rand_drain");
        bus_write(A_ST, 32'h0000_0008);
        rx_ovf_model = 1'b0;

        // Reset mid-frame on both paths
        for (int j = 0; j < 3; j++) bus_write(A_TX, {24'd0, 8'($urandom)});
        @(negedge clock); uart_rx = 1'b0;
        repeat (15) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("reset_midframe_tx", {31'd0, uart_tx}, 32'd1);
        @(negedge clock);
        reset   = 1'b0;
        uart_rx = 1'b1;
        bus_read(A_ST, rd);  chk("reset_midframe_status", rd, 32'h0000_0002);
        repeat (50) @(negedge clock);
        tx_seen.delete();
        bus_read(A_ST, rd);  chk("reset_settled_status", rd, 32'h0000_0002);
        bus_read(A_RX, rd);  chk("reset_rx_discarded", rd, 32'h8000_0000);

        // Miss address has no effect
        bus_write(32'hC000_0010, 32'h0000_0041);
        bus_read(32'hC000_0010, rd); chk("miss_read", rd, 32'd0);
        bus_read(32'hC000_0018, rd); chk("miss_read_status", rd, 32'd0);
        lows = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (uart_tx !== 1'b1) lows++;
        end
        chk("miss_no_tx", lows, 32'd0);
        chk("miss_no_frame", tx_seen.size(), 32'd0);
        bus_read(A_ST, rd);  chk("miss_status", rd, 32'h0000_0002);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
